gpio_frame_tx: RTL and testbench

Transmit engine behind the inter-FPGA GPIO link. It latches a multi-word message when the board-level data_ready flag is raised. It serialises the message byte-by-byte onto the GPIO lane using a four-phase valid/ack handshake with the peer board, then pulses done, which clears data_ready at the top level. It runs in the divided processor clock domain. The peer ack arrives asynchronously and is synchronised internally.

---
 rtl/gpio_frame_tx.sv | 87 ++++++++
 tb/tb_gpio_frame_tx.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/gpio_frame_tx.sv
// gpio_frame_tx: latches a multi-word frame and sends it byte-by-byte over a
// four-phase valid/ack GPIO handshake, with ack timeout and rearm protection.
module gpio_frame_tx #(
  parameter int NUM_WORDS   = 4,
  parameter int LANE_W      = 8,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic                            i_clock,
  input  logic                            i_reset,
  input  logic                            i_data_ready,
  input  logic [NUM_WORDS*32-1:0]         i_message_in,
  output logic [LANE_W-1:0]               o_gpio_data,
  output logic                            o_gpio_valid,
  input  logic                            i_gpio_ack,
  output logic                            o_busy,
  output logic                            o_done,
  output logic                            o_error,
  output logic [$clog2(NUM_WORDS*4)-1:0]  o_byte_idx
);
  localparam int NBITS = NUM_WORDS * 32;
  localparam int NB = NBITS / LANE_W;
  localparam int IW = $clog2(NB);
  localparam int CW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [IW-1:0] LAST = IW'(NB - 1);
  localparam logic [CW-1:0] TO_LAST = CW'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, PRESENT, RELEASE, DONE} state_t;

  state_t           r_state, w_next;
  logic             r_ack_m, r_ack_s, r_armed, r_error;
  logic [NBITS-1:0] r_shadow;
  logic [IW-1:0]    r_idx;
  logic [CW-1:0]    r_cnt;
  logic             w_accept, w_to, w_last, w_abort, w_adv;

  assign w_accept = (r_state == IDLE) && i_data_ready && r_armed && !r_ack_s;
  assign w_to     = r_cnt == TO_LAST;
  assign w_last   = r_idx == LAST;
  // ack is checked before the timeout so a coincident ack edge never aborts
  assign w_abort  = ((r_state == PRESENT) && !r_ack_s && w_to) ||
                    ((r_state == RELEASE) && r_ack_s && w_to);
  assign w_adv    = (r_state == RELEASE) && !r_ack_s && !w_last;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_accept ? PRESENT : IDLE;
      PRESENT: w_next = r_ack_s ? RELEASE : (w_to ? DONE : PRESENT);
      RELEASE: w_next = !r_ack_s ? (w_last ? DONE : PRESENT) : (w_to ? DONE : RELEASE);
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state  <= IDLE;
      r_ack_m  <= 1'b0;
      r_ack_s  <= 1'b0;
      r_armed  <= 1'b1;
      r_error  <= 1'b0;
      r_shadow <= '0;
      r_idx    <= '0;
      r_cnt    <= '0;
    end else begin
      r_state <= w_next;
      r_ack_m <= i_gpio_ack;
      r_ack_s <= r_ack_m;
      if (w_accept) r_armed <= 1'b0;
      else if (!i_data_ready) r_armed <= 1'b1;
      if (w_accept) r_error <= 1'b0;
      else if (w_abort) r_error <= 1'b1;
      if (w_accept) r_shadow <= i_message_in;
      else if (w_adv) r_shadow <= {r_shadow[NBITS-LANE_W-1:0], LANE_W'(0)};
      if (w_accept) r_idx <= '0;
      else if (w_adv) r_idx <= r_idx + 1'b1;
      if (r_state != w_next) r_cnt <= '0;
      else if (r_state == PRESENT || r_state == RELEASE) r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_gpio_valid = r_state == PRESENT;
  assign o_busy       = r_state != IDLE;
  assign o_done       = r_state == DONE;
  assign o_error      = r_error;
  assign o_byte_idx   = r_idx;
  assign o_gpio_data  = (r_state == PRESENT || r_state == RELEASE) ? r_shadow[NBITS-1 -: LANE_W] : '0;
endmodule

// File: tb/tb_gpio_frame_tx.sv
// tb_gpio_frame_tx: directed table-driven bench for gpio_frame_tx with a
// peer model that echoes valid onto ack three cycles later.
module tb_gpio_frame_tx;
  logic         clk = 1'b0, rst = 1'b1, data_ready = 1'b0, ack_force = 1'b0, peer_en = 1'b0;
  logic [127:0] msg = '0;
  logic [7:0]   gpio_data;
  logic         valid, busy, done, error, gpio_ack;
  logic [3:0]   byte_idx;
  logic [2:0]   vd = '0;

  gpio_frame_tx #(.NUM_WORDS(4), .LANE_W(8), .ACK_TIMEOUT(15)) dut (
    .i_clock(clk), .i_reset(rst), .i_data_ready(data_ready), .i_message_in(msg),
    .o_gpio_data(gpio_data), .o_gpio_valid(valid), .i_gpio_ack(gpio_ack),
    .o_busy(busy), .o_done(done), .o_error(error), .o_byte_idx(byte_idx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) vd <= {vd[1:0], valid};
  assign gpio_ack = peer_en ? vd[2] : ack_force;

  typedef struct {logic [3:0] idx; logic [7:0] data;} vec_t;
  localparam logic [127:0] M = {32'h156, 32'd3145, 32'd29455, 32'd939415};
  localparam logic [127:0] EXP = 128'h00000156_00000C49_0000730F_000E5597;

  int         checks = 0, failures = 0, done_cnt = 0;
  logic [11:0] capq[$];
  logic       prev_v = 1'b0;
  vec_t       tbl[16];

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (valid && !prev_v) capq.push_back({byte_idx, gpio_data});
    prev_v = valid;
  end

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", n, act, exp);
    end
  endtask

  task automatic wait_done(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max && !ok; i++) begin
      @(negedge clk);
      if (done) ok = 1'b1;
    end
  endtask

  task automatic check_frame(input string n);
    chk({n, "_count"}, capq.size(), 16);
    for (int k = 0; k < 16 && k < capq.size(); k++)
      chk($sformatf("%s_byte%0d", n, k), {20'd0, capq[k]}, {20'd0, tbl[k].idx, tbl[k].data});
  endtask

  initial begin
    bit ok, bad;
    int d0, vh, lat;
    logic [127:0] e;
    e = EXP;
    for (int k = 0; k < 16; k++) begin
      tbl[k].idx = 4'(k);
      tbl[k].data = e[127-8*k -: 8];
    end
    repeat (3) @(negedge clk);
    chk("reset_outputs", {16'd0, gpio_data, valid, busy, done, error, byte_idx}, 0);
    rst = 1'b0;

    bad = 1'b0;
    repeat (20) begin @(negedge clk); if (valid || busy) bad = 1'b1; end
    chk("idle_quiet", {31'd0, bad}, 0);

    capq.delete(); d0 = done_cnt;
    msg = M; data_ready = 1'b1; peer_en = 1'b1;
    @(negedge clk);
    chk("valid_latency", {31'd0, valid}, 1);
    msg = ~M;
    wait_done(400, ok);
    chk("frame_done", {31'd0, ok}, 1);
    chk("frame_err", {31'd0, error}, 0);
    chk("frame_busy_in_done", {31'd0, busy}, 1);
    chk("frame_last_idx", {28'd0, byte_idx}, 15);
    data_ready = 1'b0;
    @(negedge clk);
    chk("frame_busy_after", {31'd0, busy}, 0);
    repeat (3) @(negedge clk);
    check_frame("frame");
    chk("frame_done_pulses", done_cnt - d0, 1);

    peer_en = 1'b0; ack_force = 1'b0; capq.delete(); d0 = done_cnt; vh = 0; ok = 1'b0;
    data_ready = 1'b1;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (valid) vh++;
      if (done) ok = 1'b1;
    end
    chk("to_done", {31'd0, ok}, 1);
    chk("to_valid_cycles", vh, 15);
    chk("to_valid_low", {31'd0, valid}, 0);
    chk("to_error", {31'd0, error}, 1);

    bad = 1'b0;
    repeat (50) begin @(negedge clk); if (busy) bad = 1'b1; end
    chk("to_bytes", capq.size(), 1);
    chk("rearm_hold", {31'd0, bad}, 0);
    chk("rearm_err_sticky", {31'd0, error}, 1);
    msg = M; data_ready = 1'b0; capq.delete();
    @(negedge clk);
    data_ready = 1'b1; peer_en = 1'b1;
    @(negedge clk);
    chk("rearm_start", {31'd0, valid}, 1);
    chk("rearm_err_clear", {31'd0, error}, 0);
    wait_done(400, ok);
    chk("rearm_done", {31'd0, ok}, 1);
    data_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_frame("rearm");

    capq.delete(); d0 = done_cnt; ok = 1'b0;
    data_ready = 1'b1;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (byte_idx == 4'd5) ok = 1'b1;
    end
    chk("mid_reach5", {31'd0, ok}, 1);
    #2 rst = 1'b1;
    #1 chk("mid_reset_outputs", {16'd0, gpio_data, valid, busy, done, error, byte_idx}, 0);
    data_ready = 1'b0;
    repeat (5) @(negedge clk);
    chk("mid_no_done", done_cnt - d0, 0);
    rst = 1'b0;
    @(negedge clk);
    capq.delete(); data_ready = 1'b1;
    wait_done(400, ok);
    chk("mid_restart_done", {31'd0, ok}, 1);
    data_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_frame("mid_restart");

    peer_en = 1'b0; ack_force = 1'b1;
    repeat (3) @(negedge clk);
    data_ready = 1'b1; bad = 1'b0;
    repeat (10) begin @(negedge clk); if (busy) bad = 1'b1; end
    chk("stuck_idle", {31'd0, bad}, 0);
    ack_force = 1'b0; lat = 0; ok = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(negedge clk);
      lat++;
      if (valid) ok = 1'b1;
    end
    chk("stuck_latency", lat, 3);
    peer_en = 1'b1;
    wait_done(400, ok);
    chk("stuck_done", {31'd0, ok}, 1);
    data_ready = 1'b0;
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
